// File: rtl/daisy_chain_sink_pkg.sv
// Shared definitions for the daisy-chain sink: FSM states, chain idle word
// and the layout of a buffered entry {last, blk, ch, payload}.
package daisy_chain_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2
  } dcs_state_t;

  // Idle word on the chain is all-ones of the chain word width.
  function automatic logic [63:0] dcs_chain_idle(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic int unsigned dcs_ch_lsb(input int unsigned bits_adc);
    return bits_adc;
  endfunction

  function automatic int unsigned dcs_blk_lsb(input int unsigned bits_adc,
                                              input int unsigned ch_w);
    return bits_adc + ch_w;
  endfunction

  function automatic int unsigned dcs_last_bit(input int unsigned bits_adc,
                                               input int unsigned ch_w,
                                               input int unsigned blk_w);
    return bits_adc + ch_w + blk_w;
  endfunction

endpackage

// File: rtl/daisy_chain_sink_fifo.sv
// First-word-fall-through buffer; full/empty come from pointers carrying
// one extra wrap bit. rd_data reads as zero while empty.
module dcs_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  // A pop frees the slot this cycle, so a full buffer may still take a word.
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/daisy_chain_sink.sv
// Collects one frame of BLOCK_NUM*CH_NUM chain words per samp edge, tags each
// with block/channel and buffers it. Optional: DCHAIN_SINK_TIMEOUT_EN.
module daisy_chain_sink
  import daisy_chain_sink_pkg::*;
#(
  parameter int unsigned BLOCK_NUM   = 8,
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned BITS_ADC    = 12,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                         clk_3p2M,
  input  logic                         rst,
  input  logic                         samp,
  input  logic [BITS_ADC:0]            chain_in,
  output logic [BITS_ADC-1:0]          out_data,
  output logic [$clog2(BLOCK_NUM)-1:0] out_blk,
  output logic [$clog2(CH_NUM)-1:0]    out_ch,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_done,
  output logic                         err_short,
  output logic                         err_ovf,
`ifdef DCHAIN_SINK_TIMEOUT_EN
  output logic                         err_timeout,
`endif
  input  logic                         err_clr
);

  localparam int unsigned BLK_W    = $clog2(BLOCK_NUM);
  localparam int unsigned CH_W     = $clog2(CH_NUM);
  localparam int unsigned CH_LSB   = dcs_ch_lsb(BITS_ADC);
  localparam int unsigned BLK_LSB  = dcs_blk_lsb(BITS_ADC, CH_W);
  localparam int unsigned LAST_BIT = dcs_last_bit(BITS_ADC, CH_W, BLK_W);
  localparam int unsigned EW       = LAST_BIT + 1;

  dcs_state_t       state;
  logic             samp_q;
  logic [BLK_W-1:0] blk_idx;
  logic [CH_W-1:0]  ch_idx;

  logic             samp_rise;
  logic             in_frame;
  logic             accept;
  logic             idx_last;
  logic             pop;
  logic             drop;
  logic             tmo;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    wr_data;
  logic [EW-1:0]    rd_data;

  assign samp_rise = samp & ~samp_q;
  assign in_frame  = (state != ST_IDLE);
  assign accept    = in_frame & ~samp_rise & ~chain_in[BITS_ADC];
  assign idx_last  = (blk_idx == BLK_W'(BLOCK_NUM - 1)) && (ch_idx == CH_W'(CH_NUM - 1));
  assign pop       = out_valid & out_ready;
  assign drop      = accept & fifo_full & ~pop;

`ifdef DCHAIN_SINK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  assign tmo = in_frame & ~accept & ~samp_rise & (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_3p2M) begin
    if (rst) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!in_frame || accept || samp_rise || tmo) tcnt <= '0;
      else                                         tcnt <= tcnt + 1'b1;
      if (err_clr)  err_timeout <= 1'b0;
      else if (tmo) err_timeout <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_3p2M) begin
    if (rst) begin
      state      <= ST_IDLE;
      samp_q     <= 1'b0;
      blk_idx    <= '0;
      ch_idx     <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      samp_q     <= samp;
      frame_done <= 1'b0;
      // A new samp edge always restarts the frame, even mid-collection.
      if (samp_rise) begin
        state   <= ST_WAIT;
        blk_idx <= '0;
        ch_idx  <= '0;
      end else if (tmo) begin
        state   <= ST_IDLE;
        blk_idx <= '0;
        ch_idx  <= '0;
      end else if (accept) begin
        if (idx_last) begin
          state      <= ST_IDLE;
          blk_idx    <= '0;
          ch_idx     <= '0;
          frame_done <= 1'b1;
        end else begin
          state <= ST_COLLECT;
          if (ch_idx == CH_W'(CH_NUM - 1)) begin
            ch_idx  <= '0;
            blk_idx <= blk_idx + 1'b1;
          end else begin
            ch_idx <= ch_idx + 1'b1;
          end
        end
      end
      if (err_clr)                     err_short <= 1'b0;
      else if (samp_rise && in_frame)  err_short <= 1'b1;
      if (err_clr)   err_ovf <= 1'b0;
      else if (drop) err_ovf <= 1'b1;
    end
  end

  always_comb begin
    wr_data                     = '0;
    wr_data[BITS_ADC-1:0]       = chain_in[BITS_ADC-1:0];
    wr_data[CH_LSB +: CH_W]     = ch_idx;
    wr_data[BLK_LSB +: BLK_W]   = blk_idx;
    wr_data[LAST_BIT]           = idx_last;
  end

  dcs_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_3p2M),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = rd_data[BITS_ADC-1:0];
  assign out_ch    = rd_data[CH_LSB +: CH_W];
  assign out_blk   = rd_data[BLK_LSB +: BLK_W];
  assign out_last  = rd_data[LAST_BIT];

endmodule

// File: tb/tb_daisy_chain_sink.sv
// Directed bench for daisy_chain_sink (default parameters); timeout cases
// are built only with DCHAIN_SINK_TIMEOUT_EN.
module tb_daisy_chain_sink;
  import daisy_chain_sink_pkg::*;

  localparam int unsigned BA = 12;
  localparam int unsigned N  = 32;
  localparam logic [63:0] IDLE_WIDE = dcs_chain_idle(BA + 1);
  localparam logic [BA:0] IDLE      = IDLE_WIDE[BA:0];

  logic          clk_3p2M = 1'b0;
  logic          rst;
  logic          samp;
  logic [BA:0]   chain_in;
  logic [BA-1:0] out_data;
  logic [2:0]    out_blk;
  logic [1:0]    out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          err_short;
  logic          err_ovf;
  logic          err_clr;
`ifdef DCHAIN_SINK_TIMEOUT_EN
  logic          err_timeout;
`endif

  always #5 clk_3p2M = ~clk_3p2M;

  daisy_chain_sink #(
    .BLOCK_NUM   (8),
    .CH_NUM      (4),
    .BITS_ADC    (BA),
    .FIFO_DEPTH  (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk_3p2M    (clk_3p2M),
    .rst         (rst),
    .samp        (samp),
    .chain_in    (chain_in),
    .out_data    (out_data),
    .out_blk     (out_blk),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .err_short   (err_short),
    .err_ovf     (err_ovf),
`ifdef DCHAIN_SINK_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .err_clr     (err_clr)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [17:0] got_q[$];
  int unsigned done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Transfers complete on the next rising edge; inputs only change at posedge+1.
  always @(negedge clk_3p2M) begin
    if (out_valid === 1'b1 && out_ready === 1'b1)
      got_q.push_back({out_last, out_blk, out_ch, out_data});
    if (frame_done === 1'b1) done_cnt++;
  end

  function automatic logic [17:0] exp_entry(input int unsigned k, input int unsigned payload);
    logic       last;
    logic [2:0] blk;
    logic [1:0] ch;
    logic [11:0] pl;
    last = (k == N - 1);
    blk  = 3'(k / 4);
    ch   = 2'(k % 4);
    pl   = 12'(payload);
    return {last, blk, ch, pl};
  endfunction

  task automatic tick();
    @(posedge clk_3p2M);
    #1;
  endtask

  task automatic send_word(input int unsigned p);
    chain_in = {1'b0, 12'(p)};
    tick();
  endtask

  task automatic send_idle(input int unsigned n);
    chain_in = IDLE;
    repeat (n) tick();
  endtask

  task automatic pulse_samp();
    chain_in = IDLE;
    samp = 1'b1;
    tick();
    samp = 1'b0;
  endtask

  task automatic check_words(input string tag, input int unsigned q_base,
                             input int unsigned cnt, input int unsigned offs);
    for (int unsigned k = 0; k < cnt; k++) begin
      if (q_base + k < got_q.size())
        chk($sformatf("%s_w%0d", tag, k), 32'(got_q[q_base + k]), 32'(exp_entry(k, k + offs)));
      else
        chk($sformatf("%s_w%0d_missing", tag, k), 32'(got_q.size()), 32'(q_base + k + 1));
    end
  endtask

  initial begin
    rst = 1'b1; samp = 1'b0; chain_in = IDLE; out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'({out_last, out_blk, out_ch, out_data}), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_errs",  32'({err_short, err_ovf}), 32'd0);
`ifdef DCHAIN_SINK_TIMEOUT_EN
    chk("rst_tmo",   32'(err_timeout), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Clean frame
    out_ready = 1'b1; got_q.delete(); done_cnt = 0;
    pulse_samp();
    send_idle(3);
    for (int unsigned k = 0; k < N; k++) send_word(k);
    send_idle(4);
    chk("clean_count", 32'(got_q.size()), 32'd32);
    check_words("clean", 0, N, 0);
    chk("clean_done", 32'(done_cnt), 32'd1);
    chk("clean_errs", 32'({err_short, err_ovf}), 32'd0);

    // Idle gaps inside the frame
    got_q.delete(); done_cnt = 0;
    pulse_samp();
    send_idle(1);
    for (int unsigned k = 0; k < N; k++) begin
      send_word(k);
      if (k == 5 || k == 17) send_idle(2);
    end
    send_idle(4);
    chk("gap_count", 32'(got_q.size()), 32'd32);
    check_words("gap", 0, N, 0);
    chk("gap_done", 32'(done_cnt), 32'd1);

    // Back-pressure: 16 buffered, 16 dropped; err_clr beats the final drop
    out_ready = 1'b0; got_q.delete(); done_cnt = 0;
    pulse_samp();
    send_idle(1);
    for (int unsigned k = 0; k < N; k++) begin
      if (k == N - 1) err_clr = 1'b1;
      send_word(k);
      err_clr = 1'b0;
      if (k == 5)  chk("bp_head_stable", 32'({out_last, out_blk, out_ch, out_data}), 32'd0);
      if (k == 16) chk("bp_ovf_set_16", 32'(err_ovf), 32'd1);
      if (k == 30) chk("bp_ovf_set", 32'(err_ovf), 32'd1);
    end
    chk("bp_clr_priority", 32'(err_ovf), 32'd0);
    send_idle(1);
    chk("bp_done", 32'(done_cnt), 32'd1);
    chk("bp_no_xfer", 32'(got_q.size()), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send_idle(20);
    chk("bp_count", 32'(got_q.size()), 32'd16);
    check_words("bp", 0, 16, 0);

    // Early samp restarts the frame from index 0
    got_q.delete(); done_cnt = 0;
    pulse_samp();
    send_idle(2);
    for (int unsigned k = 0; k < 10; k++) send_word(k);
    pulse_samp();
    chk("early_short", 32'(err_short), 32'd1);
    for (int unsigned k = 0; k < N; k++) send_word(k + 100);
    send_idle(4);
    chk("early_count", 32'(got_q.size()), 32'd42);
    check_words("early_part", 0, 10, 0);
    check_words("early_full", 10, N, 100);
    chk("early_done", 32'(done_cnt), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("early_clr", 32'(err_short), 32'd0);

    // Reset mid-frame
    out_ready = 1'b0; got_q.delete(); done_cnt = 0;
    pulse_samp();
    for (int unsigned k = 0; k < 21; k++) send_word(k);
    chk("mid_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1; chain_in = IDLE;
    tick();
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_out", 32'({out_last, out_blk, out_ch, out_data}), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) send_word(k);
    send_idle(3);
    chk("mid_idle_ignores", 32'(got_q.size()), 32'd0);
    chk("mid_no_done", 32'(done_cnt), 32'd0);

`ifdef DCHAIN_SINK_TIMEOUT_EN
    got_q.delete(); done_cnt = 0;
    pulse_samp();
    send_idle(64);
    chk("tmo_set", 32'(err_timeout), 32'd1);
    send_word(7);
    send_idle(2);
    chk("tmo_idle", 32'(got_q.size()), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", 32'(err_timeout), 32'd0);
    pulse_samp();
    send_idle(63);
    send_word(0);
    chk("tmo_63_ok", 32'(err_timeout), 32'd0);
    for (int unsigned k = 1; k < N; k++) send_word(k);
    send_idle(4);
    chk("tmo_count", 32'(got_q.size()), 32'd32);
    check_words("tmo", 0, N, 0);
    chk("tmo_done", 32'(done_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
